// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, instruction codes, sequencer
// stage states and the memory-operation classification helpers.
package y86_pkg;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PCUPD     = 3'd6,
      S_HALT      = 3'd7
   } stage_e;

   // Instructions that touch data memory (loads, stores, stack ops).
   function automatic logic is_mem_op(input logic [3:0] icode);
      return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
             (icode == I_RET)    || (icode == I_PUSHQ)  || (icode == I_POPQ);
   endfunction

   // Memory operations that write rather than read.
   function automatic logic is_mem_write(input logic [3:0] icode);
      return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEMORY-state cycles spent waiting for mem_ready and flags the
// cycle in which the wait budget is exhausted.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   // Terminal count fires on the wait cycle that would bring the count to MEM_TIMEOUT.
   localparam logic [7:0] TC = 8'(MEM_TIMEOUT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: clear has priority over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = 8'd0;
      else if (en_i)
         cnt_d = cnt_q + 8'd1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = en_i && !clr_i && (cnt_q == TC);

endmodule

// File: rtl/seq_stage_controller.sv
// Y86-64 SEQ stage sequencer: walks fetch..pc-update one stage per state,
// waits on the data-memory handshake, and owns the architectural status.
module seq_stage_controller
   import y86_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        mem_ready,
   input  logic        dmem_error,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        execute_en,
   output logic        wb_en,
   output logic        pc_en,
   output logic        mem_req,
   output logic        mem_write,
   output logic [2:0]  stat,
   output logic        halted,
   output logic        busy,
   output logic [31:0] instr_count
);

   stage_e      state_q, state_d;
   logic [2:0]  stat_q, stat_d;
   logic [31:0] count_q, count_d;
   logic [3:0]  icode_q, icode_d;
   logic        fetch_q, decode_q, execute_q, wb_q, pc_q;
   logic        mreq_q, mwrite_q, halted_q, busy_q;
   logic        in_mem, tmr_tc;

   assign in_mem = (state_q == S_MEMORY);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!in_mem),
      .en_i  (in_mem && !mem_ready),
      .tc_o  (tmr_tc)
   );

   // Next-state, status and retire-count logic; icode is captured in DECODE
   // because fetch only guarantees it there.
   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      count_d = count_q;
      icode_d = icode_q;
      case (state_q)
         S_IDLE:      if (start) state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE: begin
            icode_d = icode;
            if (imem_error) begin
               stat_d  = STAT_ADR;
               state_d = S_HALT;
            end else if (!instr_valid) begin
               stat_d  = STAT_INS;
               state_d = S_HALT;
            end else if (icode == I_HALT) begin
               stat_d  = STAT_HLT;
               state_d = S_HALT;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE:   state_d = is_mem_op(icode_q) ? S_MEMORY : S_WRITEBACK;
         S_MEMORY: begin
            // A ready response beats a timeout landing on the same cycle.
            if (mem_ready) begin
               if (dmem_error) begin
                  stat_d  = STAT_ADR;
                  state_d = S_HALT;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (tmr_tc) begin
               stat_d  = STAT_ADR;
               state_d = S_HALT;
            end
         end
         S_WRITEBACK: state_d = S_PCUPD;
         S_PCUPD: begin
            count_d = count_q + 32'd1;
            state_d = S_FETCH;
         end
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_IDLE;
      endcase
   end

   // State, status and registered output decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         stat_q    <= STAT_AOK;
         count_q   <= 32'd0;
         fetch_q   <= 1'b0;
         decode_q  <= 1'b0;
         execute_q <= 1'b0;
         wb_q      <= 1'b0;
         pc_q      <= 1'b0;
         mreq_q    <= 1'b0;
         mwrite_q  <= 1'b0;
         halted_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         stat_q    <= stat_d;
         count_q   <= count_d;
         fetch_q   <= (state_d == S_FETCH);
         decode_q  <= (state_d == S_DECODE);
         execute_q <= (state_d == S_EXECUTE);
         wb_q      <= (state_d == S_WRITEBACK);
         pc_q      <= (state_d == S_PCUPD);
         mreq_q    <= (state_d == S_MEMORY);
         mwrite_q  <= (state_d == S_MEMORY) && is_mem_write(icode_d);
         halted_q  <= (state_d == S_HALT);
         busy_q    <= (state_d != S_IDLE) && (state_d != S_HALT);
      end
   end

   // Captured instruction code is datapath state and needs no reset.
   always_ff @(posedge clk) begin
      icode_q <= icode_d;
   end

   assign fetch_en    = fetch_q;
   assign decode_en   = decode_q;
   assign execute_en  = execute_q;
   assign wb_en       = wb_q;
   assign pc_en       = pc_q;
   assign mem_req     = mreq_q;
   assign mem_write   = mwrite_q;
   assign stat        = stat_q;
   assign halted      = halted_q;
   assign busy        = busy_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller: an instruction-level model expands each
// instruction into its expected stage sequence and checks every cycle.
module tb_seq_stage_controller;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst, start, instr_valid, imem_error, mem_ready, dmem_error;
   logic [3:0]  icode;
   logic        fetch_en, decode_en, execute_en, wb_en, pc_en;
   logic        mem_req, mem_write, halted, busy;
   logic [2:0]  stat;
   logic [31:0] instr_count;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [2:0]  exp_stat;
   logic [31:0] exp_count;
   logic        exp_halted;

   seq_stage_controller #(.MEM_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .icode       (icode),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .mem_ready   (mem_ready),
      .dmem_error  (dmem_error),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .execute_en  (execute_en),
      .wb_en       (wb_en),
      .pc_en       (pc_en),
      .mem_req     (mem_req),
      .mem_write   (mem_write),
      .stat        (stat),
      .halted      (halted),
      .busy        (busy),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected {fetch,decode,execute,wb,pc,mem_req,mem_write,halted,busy} for a stage.
   function automatic logic [8:0] exp_vec(input byte stg, input logic mw);
      case (stg)
         "F":     return 9'b10000_0001;
         "D":     return 9'b01000_0001;
         "E":     return 9'b00100_0001;
         "M":     return {7'b00000_10, 2'b01} | (mw ? 9'b00000_0100 : 9'b0);
         "W":     return 9'b00010_0001;
         "P":     return 9'b00001_0001;
         "H":     return 9'b00000_0010;
         default: return 9'b0;
      endcase
   endfunction

   // Check current outputs against the expected stage, then advance one cycle.
   task automatic step(input byte stg, input logic mw);
      logic [8:0] got;
      got = {fetch_en, decode_en, execute_en, wb_en, pc_en, mem_req, mem_write, halted, busy};
      chk($sformatf("cyc%0d_%c_outs", cyc, stg), {23'b0, got}, {23'b0, exp_vec(stg, mw)});
      chk($sformatf("cyc%0d_%c_stat", cyc, stg), {29'b0, stat}, {29'b0, exp_stat});
      chk($sformatf("cyc%0d_%c_count", cyc, stg), instr_count, exp_count);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic rand_inputs();
      start       = 1'($urandom_range(0, 1));
      icode       = 4'($urandom);
      instr_valid = 1'($urandom_range(0, 1));
      imem_error  = 1'($urandom_range(0, 1));
      mem_ready   = 1'($urandom_range(0, 1));
      dmem_error  = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rand_inputs();
      start = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst        = 1'b0;
      exp_stat   = 3'd1;
      exp_count  = 32'd0;
      exp_halted = 1'b0;
      step("I", 1'b0);
   endtask

   task automatic begin_run();
      rand_inputs();
      start = 1'b1;
      step("I", 1'b0);
      start = 1'b0;
   endtask

   task automatic check_halt(input int n);
      for (int k = 0; k < n; k++) begin
         rand_inputs();
         step("H", 1'b0);
      end
   endtask

   // Run one instruction. waits = cycles of mem_ready low before it rises
   // (>= TO means it never rises in time). abort_at >= 0 asserts rst in that stage.
   task automatic do_instr(input logic [3:0] ic, input logic ierr, input logic ivld,
                           input int waits, input logic derr, input int abort_at);
      byte  stg_q[$];
      byte  s;
      int   mi;
      logic fault, memop, mw, memfault;
      fault    = ierr || !ivld || (ic == 4'h0);
      memop    = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      mw       = ic inside {4'h4, 4'h8, 4'hA};
      memfault = 1'b0;
      stg_q.push_back("F");
      stg_q.push_back("D");
      if (!fault) begin
         stg_q.push_back("E");
         if (memop) begin
            for (int k = 0; k < ((waits >= TO) ? TO : waits + 1); k++)
               stg_q.push_back("M");
            memfault = (waits >= TO) || derr;
         end
         if (!memfault) begin
            stg_q.push_back("W");
            stg_q.push_back("P");
         end
      end
      mi = 0;
      for (int i = 0; i < stg_q.size(); i++) begin
         s = stg_q[i];
         rand_inputs();
         if (s == "D") begin
            icode       = ic;
            instr_valid = ivld;
            imem_error  = ierr;
         end
         if (s == "M") begin
            mem_ready = (mi == waits);
            if (mi == waits) dmem_error = derr;
            mi++;
         end
         if (i == abort_at) begin
            rst = 1'b1;
            step(s, mw);
            rst        = 1'b0;
            start      = 1'b0;
            exp_stat   = 3'd1;
            exp_count  = 32'd0;
            exp_halted = 1'b0;
            return;
         end
         step(s, mw);
      end
      if (fault) begin
         exp_stat   = ierr ? 3'd3 : (!ivld ? 3'd4 : 3'd2);
         exp_halted = 1'b1;
      end else if (memfault) begin
         exp_stat   = 3'd3;
         exp_halted = 1'b1;
      end else begin
         exp_count = exp_count + 32'd1;
      end
   endtask

   initial begin
      logic [3:0] ric;
      int         r, w;
      rst = 1'b0;
      rand_inputs();
      start = 1'b0;
      @(negedge clk);
      do_reset();
      rand_inputs();
      start = 1'b0;
      step("I", 1'b0);

      // nop, load with three wait cycles, store timing out
      begin_run();
      do_instr(4'h1, 1'b0, 1'b1, 0, 1'b0, -1);
      do_instr(4'h5, 1'b0, 1'b1, 3, 1'b0, -1);
      do_instr(4'h4, 1'b0, 1'b1, 40, 1'b0, -1);
      check_halt(5);

      // ready on the last allowed cycle wins over timeout; then dmem error
      do_reset();
      begin_run();
      do_instr(4'hA, 1'b0, 1'b1, TO - 1, 1'b0, -1);
      do_instr(4'h9, 1'b0, 1'b1, 1, 1'b1, -1);
      check_halt(3);

      // decode faults in priority order
      do_reset();
      begin_run();
      do_instr(4'h1, 1'b1, 1'b0, 0, 1'b0, -1);
      check_halt(6);
      do_reset();
      begin_run();
      do_instr(4'h6, 1'b0, 1'b0, 0, 1'b0, -1);
      check_halt(4);
      do_reset();
      begin_run();
      do_instr(4'h0, 1'b0, 1'b1, 0, 1'b0, -1);
      check_halt(4);

      // reset while mem_req is high
      do_reset();
      begin_run();
      do_instr(4'h2, 1'b0, 1'b1, 0, 1'b0, -1);
      do_instr(4'h8, 1'b0, 1'b1, 5, 1'b0, 4);
      rand_inputs();
      start = 1'b0;
      step("I", 1'b0);

      // three nops then halt
      begin_run();
      for (int k = 0; k < 3; k++) do_instr(4'h1, 1'b0, 1'b1, 0, 1'b0, -1);
      do_instr(4'h0, 1'b0, 1'b1, 0, 1'b0, -1);
      check_halt(20);

      // randomized instruction stream
      do_reset();
      begin_run();
      for (int n = 0; n < 80; n++) begin
         r   = $urandom_range(0, 99);
         ric = 4'($urandom_range(1, 11));
         if (r >= 6 && r < 8) ric = 4'h0;
         w = (r < 90) ? $urandom_range(0, 4) : $urandom_range(0, TO + 3);
         do_instr(ric, r < 3, !(r >= 3 && r < 6), w, $urandom_range(0, 19) == 0, -1);
         if (exp_halted) begin
            check_halt(3);
            do_reset();
            begin_run();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
